risc_toy_dmem: RTL
==================

// Module: risc_toy_dmem
// PURPOSE
//  Data-memory responder for the RISC_TOY core's D-port: the target end of DREQ/DRW/DADDR/DWDATA/DRDATA.
//  Word-addressed synchronous SRAM model with a fixed read latency and address-window checking.
//  Also provides a testbench backdoor load port, sticky error flag and saturating access counters.
//  Sits beside the core in the top-level/testbench; core-side timing is fixed-latency, no ready signal.
// PARAMETERS
//  AW      10      index width; DEPTH = 2**AW words
//  RD_LAT  1       read latency in clock edges, legal 1..4 (other values: elaboration error)
//  BASE    30'h0   word address mapped to array index 0
// PORTS
//  CLK      in   1   clock, rising edge
//  RSTN     in   1   reset, asynchronous, active-low
//  DREQ     in   1   core access request, sampled each rising edge
//  DRW      in   1   1 = write, 0 = read (valid with DREQ)
//  DADDR    in   30  word address (byte address [31:2])
//  DWDATA   in   32  write data (valid with DREQ & DRW)
//  DRDATA   out  32  read data, RD_LAT edges after request
//  BL_EN    in   1   backdoor write enable (testbench preload)
//  BL_ADDR  in   AW  backdoor array index
//  BL_DATA  in   32  backdoor write data
//  ERR      out  1   sticky: out-of-window core access or dropped write
//  RD_CNT   out  16  accepted core reads, saturating
//  WR_CNT   out  16  performed core writes, saturating
// BEHAVIOUR
//  Reset: clock CLK; reset RSTN, asynchronous, active-low. DRDATA=0, ERR=0, RD_CNT=0, WR_CNT=0,
//   read pipeline valid bits cleared. Array contents not reset. Reset mid-read: in-flight results
//   discarded; DRDATA=0 until a new read completes.
//  Decode: off = DADDR - BASE (30-bit, mod 2^30); in-window iff off < DEPTH; idx = off[AW-1:0].
//  Write (edge N, DREQ&DRW, in-window, !BL_EN): mem[idx] <= DWDATA; WR_CNT++.
//  Read (edge N, DREQ&!DRW): array sampled at edge N (pre-write value is irrelevant: single port,
//   one access/cycle); result enters an RD_LAT-deep shift pipe; DRDATA updates at edge N+RD_LAT-1
//   so it is visible during cycle N+RD_LAT relative to request cycle N (RD_LAT=1: next cycle).
//   RD_CNT++ at edge N. Out-of-window read returns 32'hDEAD_BEEF and sets ERR.
//  DRDATA holds the last completed read result; writes and idle cycles do not change it.
//  Back-to-back reads: one result per cycle, in order, no bubbles.
//  Read-after-write: write at edge N, read of same address at edge N+1 returns new data.
//  Write then pending read of same address: read already sampled returns old value (sample-time data).
//  Out-of-window write: dropped, ERR<=1, WR_CNT unchanged.
//  BL_EN: mem[BL_ADDR] <= BL_DATA at the edge; has priority. A simultaneous core write is dropped
//   and sets ERR; a simultaneous core read is served normally (sees pre-edge contents).
//  Counters saturate at 16'hFFFF; ERR cleared only by reset.
// TESTING
//  1 Backdoor load mem[5]=32'h1234_5678; read DADDR=5 at edge N -> DRDATA=32'h1234_5678 after RD_LAT edges.
//  2 Write DADDR=3 data 32'hA5A5_0001 then read 3 next cycle -> 32'hA5A5_0001; WR_CNT=1, RD_CNT=1.
//  3 Reads of 0,1,2,3 on consecutive cycles (mem[i]=i+100) -> DRDATA 100,101,102,103 on consecutive cycles.
//  4 BASE=30'h100: read DADDR=30'h0FF -> 32'hDEAD_BEEF, ERR=1; write DADDR=30'h500 -> array unchanged.
//  5 BL_EN with core write same cycle -> backdoor value stored, core write dropped, ERR=1, WR_CNT unchanged.
//  6 Assert RSTN=0 with a read in flight (RD_LAT=3) -> DRDATA stays 0, counters 0, array data retained.

Source files
------------

// File: rtl/risc_toy_dmem.sv
// Data-memory responder for the RISC_TOY D-port: word-addressed SRAM model with fixed read latency,
// address-window decode, testbench backdoor load, sticky error flag and saturating access counters.
module risc_toy_dmem #(
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 1,
  parameter logic [29:0] BASE   = 30'h0
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  input  logic          BL_EN,
  input  logic [AW-1:0] BL_ADDR,
  input  logic [31:0]   BL_DATA,
  output logic          ERR,
  output logic [15:0]   RD_CNT,
  output logic [15:0]   WR_CNT
);

  localparam int unsigned DEPTH    = 32'd1 << AW;
  localparam logic [31:0] OOW_DATA = 32'hDEAD_BEEF;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("risc_toy_dmem: RD_LAT must be in 1..4");
  end

  // An offset is inside the window when no bit above the index field is set.
  function automatic logic in_window(input logic [29:0] off);
    return ((off >> AW) == 30'd0);
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [29:0]   off_s;
  logic          in_win_s;
  logic [AW-1:0] idx_s;
  logic          rd_fire_s;
  logic          wr_fire_s;
  logic          err_set_s;
  logic [31:0]   rd_val_s;

  logic          pv_q [3];
  logic [31:0]   pd_q [3];
  logic          fin_v_s;
  logic [31:0]   fin_d_s;

  logic [31:0]   drdata_q, drdata_d;
  logic          err_q, err_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;

  // Address decode and access qualification
  always_comb begin
    off_s     = DADDR - BASE;
    in_win_s  = in_window(off_s);
    idx_s     = off_s[AW-1:0];
    rd_fire_s = DREQ & ~DRW;
    wr_fire_s = DREQ & DRW & in_win_s & ~BL_EN;
    err_set_s = DREQ & (~in_win_s | (DRW & BL_EN));
    if (in_win_s) begin
      rd_val_s = mem_q[idx_s];
    end else begin
      rd_val_s = OOW_DATA;
    end
  end

  // Array write port; the backdoor wins over a same-cycle core write
  always_ff @(posedge CLK) begin
    if (BL_EN) begin
      mem_q[BL_ADDR] <= BL_DATA;
    end else if (wr_fire_s) begin
      mem_q[idx_s] <= DWDATA;
    end
  end

  // Read-pipe valid bits, cleared by reset so in-flight reads are discarded
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pv_q[0] <= 1'b0;
      pv_q[1] <= 1'b0;
      pv_q[2] <= 1'b0;
    end else begin
      pv_q[0] <= rd_fire_s;
      pv_q[1] <= pv_q[0];
      pv_q[2] <= pv_q[1];
    end
  end

  // Read-pipe data, qualified by the valid bits
  always_ff @(posedge CLK) begin
    pd_q[0] <= rd_val_s;
    pd_q[1] <= pd_q[0];
    pd_q[2] <= pd_q[1];
  end

  // Pipe tap: DRDATA itself is the last of the RD_LAT stages
  always_comb begin
    fin_v_s = rd_fire_s;
    fin_d_s = rd_val_s;
    case (RD_LAT)
      32'd2: begin
        fin_v_s = pv_q[0];
        fin_d_s = pd_q[0];
      end
      32'd3: begin
        fin_v_s = pv_q[1];
        fin_d_s = pd_q[1];
      end
      32'd4: begin
        fin_v_s = pv_q[2];
        fin_d_s = pd_q[2];
      end
      default: begin
        fin_v_s = rd_fire_s;
        fin_d_s = rd_val_s;
      end
    endcase
  end

  // Next-state for read data, sticky error and saturating counters
  always_comb begin
    drdata_d = drdata_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (fin_v_s) begin
      drdata_d = fin_d_s;
    end else begin
      drdata_d = drdata_q;
    end
    if (err_set_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    if (rd_fire_s && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (wr_fire_s && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Output and status registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      drdata_q <= 32'h0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      drdata_q <= drdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign DRDATA = drdata_q;
  assign ERR    = err_q;
  assign RD_CNT = rd_cnt_q;
  assign WR_CNT = wr_cnt_q;

endmodule
